// File: rtl/conv_tile_loader.sv
// conv_tile_loader: serial front end for the single-PE 3x3 convolution engine.
// Collects 9 weights + 16 activations from a byte stream into parallel registers,
// kicks the engine, captures its four 2x2 results and streams them back out.
module conv_tile_loader #(
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  input  logic [7:0]   s_data,
  output logic         s_ready,
  output logic [71:0]  w_flat,
  output logic [127:0] in_flat,
  output logic         conv_start,
  input  logic         conv_done,
  input  logic [31:0]  conv_res,
  output logic         m_valid,
  output logic [7:0]   m_data,
  output logic         m_last,
  input  logic         m_ready,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitDone,
    StDrain
  } state_e;

  state_e         r_state;
  logic [4:0]     r_k;
  logic [15:0]    r_cnt;
  logic [1:0]     r_beat;
  logic [31:0]    r_res;
  logic [71:0]    r_w;
  logic [127:0]   r_in;
  logic           r_s_ready;
  logic           r_conv_start;
  logic           r_m_valid;
  logic [7:0]     r_m_data;
  logic           r_m_last;
  logic           r_busy;
  logic           r_err;

  logic           w_accept;
  logic [3:0]     w_w_slot;
  logic [3:0]     w_in_slot;
  logic [15:0]    w_cnt_next;
  logic           w_timeout;
  logic [1:0]     w_beat_next;

  assign w_accept    = r_s_ready && s_valid;
  assign w_w_slot    = r_k[3:0];
  // Activation slot is the byte index minus the 9 weight bytes in front of it.
  assign w_in_slot   = 4'(r_k - 5'd9);
  assign w_cnt_next  = r_cnt + 16'd1;
  assign w_timeout   = (w_cnt_next == 16'(DONE_TIMEOUT));
  assign w_beat_next = r_beat + 2'd1;

  assign s_ready    = r_s_ready;
  assign w_flat     = r_w;
  assign in_flat    = r_in;
  assign conv_start = r_conv_start;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign busy       = r_busy;
  assign err        = r_err;

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_k          <= '0;
      r_cnt        <= '0;
      r_beat       <= '0;
      r_res        <= '0;
      r_w          <= '0;
      r_in         <= '0;
      r_s_ready    <= 1'b0;
      r_conv_start <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_busy       <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_state   <= StLoad;
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
        end

        StLoad: begin
          if (w_accept) begin
            if (r_k < 5'd9) begin
              r_w[{w_w_slot, 3'b000} +: 8] <= s_data;
            end else begin
              r_in[{w_in_slot, 3'b000} +: 8] <= s_data;
            end
            if (r_k == 5'd24) begin
              r_k          <= '0;
              r_state      <= StStart;
              r_s_ready    <= 1'b0;
              r_busy       <= 1'b1;
              r_conv_start <= 1'b1;
            end else begin
              r_k <= r_k + 5'd1;
            end
          end
        end

        StStart: begin
          r_conv_start <= 1'b0;
          r_cnt        <= '0;
          r_state      <= StWaitDone;
        end

        StWaitDone: begin
          // Done is checked first so it wins over a timeout on the same edge.
          if (conv_done) begin
            r_res     <= conv_res;
            r_m_data  <= conv_res[7:0];
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b0;
            r_beat    <= '0;
            r_cnt     <= '0;
            r_state   <= StDrain;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_res     <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b0;
            r_beat    <= '0;
            r_cnt     <= '0;
            r_state   <= StDrain;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        StDrain: begin
          if (r_m_valid && m_ready) begin
            if (r_beat == 2'd3) begin
              r_beat    <= '0;
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_m_data  <= '0;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= StLoad;
            end else begin
              r_beat   <= w_beat_next;
              r_m_data <= r_res[{w_beat_next, 3'b000} +: 8];
              r_m_last <= (w_beat_next == 2'd3);
            end
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_loader.sv
// Self-checking bench for conv_tile_loader: random tiles, a behavioural engine,
// backpressure, timeout and mid-drain reset scenarios.
module tb_conv_tile_loader;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic [7:0]   s_data;
  logic         s_ready;
  logic [71:0]  w_flat;
  logic [127:0] in_flat;
  logic         conv_start;
  logic         conv_done;
  logic [31:0]  conv_res;
  logic         m_valid;
  logic [7:0]   m_data;
  logic         m_last;
  logic         m_ready;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tile [25];
  logic        eng_en;
  int          eng_lat;
  logic        force_en;
  logic [31:0] force_res;
  int          eng_cnt;
  logic        eng_done;
  logic [31:0] eng_res;
  logic        spur_done;

  always #5 clk = ~clk;

  conv_tile_loader #(.DONE_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .w_flat     (w_flat),
    .in_flat    (in_flat),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .conv_res   (conv_res),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .err        (err)
  );

  assign conv_done = eng_done | spur_done;
  assign conv_res  = eng_res;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 2x2 valid convolution of a 4x4 tile by a 3x3 kernel, 8-bit wrap-around.
  function automatic logic [31:0] conv_ref(input logic [71:0] w, input logic [127:0] a);
    logic [31:0] r;
    logic [7:0]  acc;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc = '0;
        for (int rr = 0; rr < 3; rr++) begin
          for (int cc = 0; cc < 3; cc++) begin
            acc = acc + w[8*(3*rr+cc) +: 8] * a[8*(4*(i+rr)+(j+cc)) +: 8];
          end
        end
        r[8*(2*i+j) +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [71:0] pack_w();
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = tile[k];
    return v;
  endfunction

  function automatic logic [127:0] pack_in();
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = tile[9+k];
    return v;
  endfunction

  // Behavioural engine: answers conv_start after eng_lat cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
      eng_res  <= '0;
    end else begin
      eng_done <= 1'b0;
      if (conv_start && eng_en) begin
        eng_cnt <= eng_lat;
      end else if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          eng_done <= 1'b1;
          eng_res  <= force_en ? force_res : conv_ref(w_flat, in_flat);
        end
      end
    end
  end

  task automatic rand_tile();
    for (int k = 0; k < 25; k++) tile[k] = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; spur_done = 1'b0;
    #2;
    check("rst_s_ready", s_ready, 0);
    check("rst_conv_start", conv_start, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 1);
    check("rst_err", err, 0);
    check("rst_w_flat", w_flat, 0);
    check("rst_in_flat", in_flat, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", s_ready, 0);
    check("idle_busy", busy, 1);
    @(negedge clk);
    check("load_s_ready", s_ready, 1);
    check("load_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [7:0] b);
    int t = 0;
    s_valid = 1'b1; s_data = b;
    @(negedge clk);
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    if (!s_ready) begin
      check("push_timeout", s_ready, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic load_tile(input bit gaps, input bit spur, input bit hold);
    logic [71:0]  we;
    logic [127:0] ie;
    we = pack_w();
    ie = pack_in();
    for (int i = 0; i < 25; i++) begin
      push(tile[i]);
      if (gaps && (i % 4 == 3) && i < 24) begin
        s_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
          spur_done = spur && (g == 0);
          @(posedge clk); #1;
        end
        spur_done = 1'b0;
        check("gap_s_ready", s_ready, 1);
        check("gap_no_start", conv_start, 0);
      end
    end
    s_valid = hold; s_data = 8'hEE;
    @(negedge clk);
    check("start_pulse", conv_start, 1);
    check("start_busy", busy, 1);
    check("start_s_ready", s_ready, 0);
    check("start_w_flat", w_flat, we);
    check("start_in_flat", in_flat, ie);
    check("start_w11", w_flat[7:0], tile[0]);
    check("start_in44", in_flat[127:120], tile[24]);
    @(negedge clk);
    check("start_one_cycle", conv_start, 0);
  endtask

  // mode 0: ready tied high, 1: pattern 1,0,0,1, 2: random ready.
  task automatic drain(input logic [31:0] exp, input int mode, input int stop);
    int         idx = 0;
    int         t = 0;
    int         p = 0;
    int         first = -1;
    logic       held = 1'b0;
    logic       prev_done;
    logic       rdy;
    logic [7:0] hd = '0;
    logic       hl = 1'b0;
    prev_done = conv_done;
    while (idx < stop && t < 400) begin
      @(negedge clk); t++;
      if (prev_done) check("valid_after_done", m_valid, 1);
      if (held) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hd);
        check("hold_last", m_last, hl);
      end
      check("drain_s_ready", s_ready, 0);
      check("drain_no_start", conv_start, 0);
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (p % 4 == 0) || (p % 4 == 3);
      else                rdy = 1'($urandom_range(0, 1));
      if (m_valid) p++;
      m_ready = rdy;
      held = m_valid && !rdy; hd = m_data; hl = m_last;
      prev_done = conv_done;
      if (m_valid && rdy) begin
        if (first < 0) first = t;
        check("beat_data", m_data, exp[8*idx +: 8]);
        check("beat_last", m_last, idx == 3);
        idx++;
        if (idx == 4) begin
          s_valid = 1'b0;
          if (mode == 0) check("beats_back_to_back", t - first, 3);
        end
      end
    end
    if (idx < stop) check("drain_timeout", idx, stop);
    if (stop == 4) begin
      @(negedge clk);
      m_ready = 1'b0;
      check("reload_s_ready", s_ready, 1);
      check("reload_m_valid", m_valid, 0);
      check("reload_busy", busy, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; spur_done = 1'b0;
    eng_en = 1'b1; eng_lat = 3; force_en = 1'b0; force_res = '0;
    do_reset();

    // Basic tile: weights 1, activations 1..16.
    for (int k = 0; k < 9; k++) tile[k] = 8'd1;
    for (int k = 0; k < 16; k++) tile[9+k] = 8'(k + 1);
    load_tile(0, 0, 0);
    drain(32'h635A3F36, 0, 4);
    check("basic_err", err, 0);

    // Same data with input gaps and a spurious done during LOAD.
    eng_lat = 6;
    load_tile(1, 1, 0);
    drain(32'h635A3F36, 0, 4);

    // Backpressure pattern with s_valid held high through WAIT_DONE/DRAIN.
    rand_tile();
    eng_lat = 4;
    load_tile(0, 0, 1);
    drain(conv_ref(pack_w(), pack_in()), 1, 4);

    // Random tiles, random engine latency, random ready.
    for (int n = 0; n < 4; n++) begin
      rand_tile();
      eng_lat = $urandom_range(1, 10);
      load_tile(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
      drain(conv_ref(pack_w(), pack_in()), 2, 4);
    end

    // Reset in the middle of DRAIN after two beats, then a full tile.
    rand_tile();
    load_tile(0, 0, 0);
    drain(conv_ref(pack_w(), pack_in()), 0, 2);
    @(posedge clk); #1;
    do_reset();
    rand_tile();
    eng_lat = 2;
    load_tile(0, 0, 0);
    drain(conv_ref(pack_w(), pack_in()), 0, 4);

    // Done arriving on the same edge the timeout count is reached.
    rand_tile();
    eng_lat = TO - 1;
    force_en = 1'b1; force_res = $urandom;
    load_tile(0, 0, 0);
    drain(force_res, 0, 4);
    check("done_wins_err", err, 0);
    force_en = 1'b0;

    // Timeout with no engine response.
    rand_tile();
    eng_en = 1'b0;
    load_tile(0, 0, 0);
    found = -1;
    for (int j = 2; j <= TO + 3 && found < 0; j++) begin
      @(negedge clk);
      if (j == TO - 1) begin
        check("no_err_early", err, 0);
        check("no_valid_early", m_valid, 0);
      end
      if (err) found = j;
    end
    check("err_window", (found >= TO) && (found <= TO + 2), 1);
    drain(32'h0, 0, 4);
    check("err_sticky", err, 1);

    // Second tile after timeout: driven result returned, err stays set.
    eng_en = 1'b1; eng_lat = 5;
    force_en = 1'b1; force_res = $urandom;
    rand_tile();
    load_tile(0, 0, 0);
    drain(force_res, 2, 4);
    check("err_still_set", err, 1);
    force_en = 1'b0;

    // Reset clears the sticky error.
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_tile_loader.md
# conv_tile_loader

Upstream feeder and result collector for the single-PE 3x3 convolution engine. Accepts a byte stream (9 kernel weights, then 16 activations of a 4x4 tile) over a valid/ready interface and holds the tile in parallel registers. It pulses the engine's start, waits for its done, and captures the four 8-bit 2x2 results. It then returns those results as a 4-beat valid/ready output stream, so the engine sits behind a simple serial link instead of 200+ parallel wires.

## Interface
- DONE_TIMEOUT, 255: cycles to wait in WAIT_DONE before giving up (1..65535)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_ready  out  1  loader can accept a byte
- w_flat  out  72  kernel to engine; w_RC at bits [8*(3*(R-1)+(C-1)) +: 8] (w_11 at [7:0], w_33 at [71:64])
- in_flat  out  128  tile to engine; in_RC at bits [8*(4*(R-1)+(C-1)) +: 8] (in_11 at [7:0], in_44 at [127:120])
- conv_start  out  1  one-cycle start pulse to engine
- conv_done  in  1  engine done pulse
- conv_res  in  32  engine results {out_22, out_21, out_12, out_11}, out_11 in [7:0]
- m_valid  out  1  result byte valid
- m_data  out  8  result byte
- m_last  out  1  high on the 4th result beat
- m_ready  in  1  downstream accepts result byte
- busy  out  1  high in every state except LOAD
- err  out  1  sticky timeout flag, cleared only by rst

## Operation
- States:
  - IDLE -> LOAD (unconditional, one cycle; entered only from reset).
  - LOAD -> START when the 25th byte is accepted.
  - START -> WAIT_DONE.
  - WAIT_DONE -> DRAIN on conv_done or on timeout.
  - DRAIN -> LOAD after the 4th output handshake.
- LOAD:
  - s_ready=1. A byte is accepted when s_valid && s_ready.
  - 5-bit byte counter k increments per accept. Byte k=0..8 writes w_flat slot k (row-major w_11..w_33). Byte k=9..24 writes in_flat slot k-9 (row-major in_11..in_44).
  - Counter clears on leaving LOAD.
  - s_ready=0 in all other states; bytes offered there are not consumed.
- START: conv_start=1 for exactly this one cycle.
- w_flat/in_flat are written only during LOAD. They are therefore stable from START through the end of DRAIN, which the engine requires because it reads them combinationally for its whole run.
- WAIT_DONE:
  - A 16-bit counter increments each cycle.
  - On conv_done=1, conv_res is captured into the 4-byte result register.
  - If the counter reaches DONE_TIMEOUT without conv_done: err<=1 and the result register loads 0x00000000.
  - conv_done in any other state is ignored.
- DRAIN:
  - Emits bytes in order out_11, out_12, out_21, out_22, with m_last=1 on out_22.
  - m_valid=1 throughout DRAIN.
  - m_data/m_last are held stable while m_valid && !m_ready.
  - The beat index advances only on m_valid && m_ready.
- No arithmetic is done in this block; results pass through unmodified.

## Timing
- Reset values:
  - state=IDLE.
  - s_ready=0, conv_start=0, m_valid=0, m_last=0, m_data=0, busy=1, err=0.
  - w_flat=0, in_flat=0, result register=0, all counters 0.
- First cycle after rst deassert: IDLE (s_ready=0). Next cycle: LOAD (s_ready=1).
- The 25th accept at edge N puts START in cycle N+1 (conv_start high), and WAIT_DONE from N+2.
- conv_done sampled high at edge M: results captured at M; first m_valid in cycle M+1.
- With m_ready tied 1: 4 consecutive beats, then s_ready=1 in the cycle after the 4th beat.
- Throughput-bound case: 25 load + 1 start + engine latency + 4 drain cycles per tile. No overlap of load with compute.
- Timeout: conv_start at cycle S with no conv_done gives err=1 and m_valid=1 no earlier than S+DONE_TIMEOUT.
- conv_done in the same cycle the timeout count is reached: done wins. Results are captured and err is unchanged.
- rst asserted mid-operation (any state): immediate return to reset values. Partially loaded bytes and undrained results are discarded. err clears.
- All outputs are registered or decoded from state only. There are no combinational paths from s_valid/m_ready/conv_done to outputs.

## Test plan
- Basic: reset, stream weights all 0x01, then activations 0x01..0x10 with s_valid continuous, real engine attached.
  - conv_start pulses once, exactly 1 cycle after the 25th accept.
  - Output beats are 0x36, 0x3F, 0x5A, 0x63, with m_last on 0x63.
  - err=0.
- Input gaps: same data as the basic test, with s_valid dropped for 3 cycles after every 4th byte.
  - Identical outputs.
  - w_flat[7:0]=0x01 and in_flat[127:120]=0x10 at START.
- Output backpressure: m_ready toggled 1,0,0,1,...
  - Each byte is held stable until its handshake.
  - No byte is dropped or duplicated.
  - s_ready rises only after the 4th handshake.
- Timeout: DONE_TIMEOUT=16, conv_done tied 0.
  - err=1 at START+16.
  - Outputs 0x00 x4.
  - A second tile with conv_done driven after 5 cycles returns the driven conv_res and err stays 1.
- Spurious/ignored inputs:
  - conv_done pulsed during LOAD: no state change.
  - s_valid held high during WAIT_DONE and DRAIN: no bytes consumed, and the counter is 0 at next LOAD.
- Reset mid-DRAIN after 2 beats: all outputs return to reset values, w_flat=in_flat=0, and a following full tile produces correct results.
